// File: rtl/div_arbiter_pkg.sv
// Shared types and helpers for the round-robin divider arbiter.
package div_arbiter_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } div_arb_state_t;

  function automatic int TAG_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import div_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = TAG_W(N)
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [TW-1:0] idx
);

  logic          found;
  logic [TW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = TW'((int'(ptr) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters, round-robin.
// Optional: DIV_ARBITER_ZERO_BYPASS_EN answers divide-by-zero locally.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic [NUM_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]         resp_quotient_out,
  output logic [WIDTH-1:0]         resp_remainder_out,
  output logic                     resp_error_out,
  output logic [WIDTH-1:0]         div_dividend_out,
  output logic [WIDTH-1:0]         div_divisor_out,
  output logic                     div_valid_out,
  input  logic                     div_busy_in,
  input  logic [WIDTH-1:0]         div_quotient_in,
  input  logic [WIDTH-1:0]         div_remainder_in,
  input  logic                     div_valid_in,
  input  logic                     div_error_in
);

  localparam int TW = TAG_W(NUM_REQ);

  div_arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0][WIDTH-1:0] dvd_arr, dvs_arr;
  logic [NUM_REQ-1:0]            gnt;
  logic [TW-1:0]                 gnt_idx;
  logic [TW-1:0]                 owner, rr_ptr;
  logic [WIDTH-1:0]              op_a, op_b, res_q, res_r;
  logic                          res_e;
  logic                          accept, bypass, capture;

  assign dvd_arr = req_dividend_in;
  assign dvs_arr = req_divisor_in;

  rr_pick #(.N(NUM_REQ), .TW(TW)) u_pick (
    .req (req_valid_in),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign accept  = (state == IDLE) && (|req_valid_in);
  assign capture = (state == WAIT) && div_valid_in;

`ifdef DIV_ARBITER_ZERO_BYPASS_EN
  assign bypass = accept && (dvs_arr[gnt_idx] == '0);
`else
  assign bypass = 1'b0;
`endif

  // Grant is combinational from the picker, but gated off while reset is held.
  assign req_ready_out = (rst_n_in && state == IDLE) ? gnt : '0;
  assign div_valid_out = (state == ISSUE) && !div_busy_in;

  assign div_dividend_out   = op_a;
  assign div_divisor_out    = op_b;
  assign resp_quotient_out  = res_q;
  assign resp_remainder_out = res_r;
  assign resp_error_out     = res_e;

  always_comb begin
    resp_valid_out = '0;
    if (state == RESPOND) resp_valid_out[owner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bypass ? RESPOND : ISSUE;
      ISSUE:   if (!div_busy_in) state_nxt = WAIT;
      WAIT:    if (div_valid_in) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      res_q  <= '0;
      res_r  <= '0;
      res_e  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a  <= dvd_arr[gnt_idx];
        op_b  <= dvs_arr[gnt_idx];
        owner <= gnt_idx;
      end
      if (bypass) begin
        res_q <= '0;
        res_r <= '0;
        res_e <= 1'b1;
      end else if (capture) begin
        res_q <= div_quotient_in;
        res_r <= div_remainder_in;
        res_e <= div_error_in;
      end
      if (state == RESPOND)
        rr_ptr <= (owner == TW'(NUM_REQ - 1)) ? '0 : owner + TW'(1);
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter with a behavioural divider and arbiter model.
module tb_div_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_dvd = '0, req_dvs = '0;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_q, resp_r, div_dvd, div_dvs;
  logic           resp_e, div_start;
  logic           div_busy = 1'b0, div_vin = 1'b0, div_e = 1'b0;
  logic [W-1:0]   div_q = '0, div_r = '0;

  div_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .req_valid_in       (req_valid),
    .req_dividend_in    (req_dvd),
    .req_divisor_in     (req_dvs),
    .req_ready_out      (req_ready),
    .resp_valid_out     (resp_valid),
    .resp_quotient_out  (resp_q),
    .resp_remainder_out (resp_r),
    .resp_error_out     (resp_e),
    .div_dividend_out   (div_dvd),
    .div_divisor_out    (div_dvs),
    .div_valid_out      (div_start),
    .div_busy_in        (div_busy),
    .div_quotient_in    (div_q),
    .div_remainder_in   (div_r),
    .div_valid_in       (div_vin),
    .div_error_in       (div_e)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [W-1:0] dvd[N], dvs[N];
  int ptr_m = 0, last_w = -1;
  int served[N];
  logic [W-1:0] last_q = '0, last_r = '0;
  logic         last_e = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_dvd[i*W +: W] = dvd[i];
      req_dvs[i*W +: W] = dvs[i];
    end
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] d;
    dvd[i] = $urandom;
    d = W'($urandom_range(1, 1000));
    if ($urandom_range(0, 1) == 1) d = -d;
    dvs[i] = ($urandom_range(0, 7) == 0) ? '0 : d;
  endtask

  // Arbiter model: first valid requester scanning upward from the pointer.
  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // Divider model: signed truncating division; zero divisor flags an error.
  task automatic div_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1; r = a; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; e = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
  endtask

  task automatic txn(input logic [N-1:0] mask, input int s, input int d);
    int w;
    logic [W-1:0] a, b, q, r;
    logic e, zb;
    @(posedge clk); #1;
    req_valid = mask;
    pack();
    div_busy = 1'b0;
    div_vin  = 1'($urandom);
    div_q    = $urandom;
    div_r    = $urandom;
    div_e    = 1'($urandom);
    #1;
    chk("hold_q", 64'(resp_q), 64'(last_q));
    chk("hold_r", 64'(resp_r), 64'(last_r));
    chk("hold_e", 64'(resp_e), 64'(last_e));
    w = pick(mask);
    chk("grant", 64'(req_ready), 64'd1 << w);
    a = dvd[w];
    b = dvs[w];
    zb = 1'b0;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
    zb = (b == '0);
`endif
    if (zb) begin
      q = '0; r = '0; e = 1'b1;
      @(posedge clk); #1;
      div_vin = 1'b0;
      #1;
      chk("bypass_nostart", 64'(div_start), 64'd0);
    end else begin
      repeat (s) begin
        @(posedge clk); #1;
        div_busy = 1'b1;
        div_vin  = 1'($urandom);
        #1;
        chk("stall_nostart", 64'(div_start), 64'd0);
        chk("stall_opa", 64'(div_dvd), 64'(a));
        chk("stall_opb", 64'(div_dvs), 64'(b));
      end
      @(posedge clk); #1;
      div_busy = 1'b0;
      div_vin  = 1'b0;
      #1;
      chk("start", 64'(div_start), 64'd1);
      chk("start_opa", 64'(div_dvd), 64'(a));
      chk("start_opb", 64'(div_dvs), 64'(b));
      chk("busy_noready", 64'(req_ready), 64'd0);
      div_ref(a, b, q, r, e);
      repeat (d - 1) begin
        @(posedge clk); #1;
        div_busy = 1'($urandom);
        #1;
        chk("wait_nostart", 64'(div_start), 64'd0);
        chk("wait_noresp", 64'(resp_valid), 64'd0);
      end
      @(posedge clk); #1;
      div_vin = 1'b1; div_q = q; div_r = r; div_e = e; div_busy = 1'b0;
      #1;
      chk("early_resp", 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
      div_vin = 1'b0; div_q = $urandom; div_r = $urandom; div_e = 1'b0;
      #1;
    end
    chk("resp_valid", 64'(resp_valid), 64'd1 << w);
    chk("resp_q", 64'(resp_q), 64'(q));
    chk("resp_r", 64'(resp_r), 64'(r));
    chk("resp_e", 64'(resp_e), 64'(e));
    last_q = q; last_r = r; last_e = e;
    ptr_m  = (w + 1) % N;
    last_w = w;
    served[w]++;
    rand_op(w);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_respv"}, 64'(resp_valid), 64'd0);
    chk({tag, "_start"}, 64'(div_start), 64'd0);
    chk({tag, "_ops"}, {div_dvd, div_dvs}, 64'd0);
    chk({tag, "_res"}, {resp_q, resp_r}, 64'd0);
    chk({tag, "_err"}, 64'(resp_e), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rand_op(i);
      served[i] = 0;
    end
    pack();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;

    // Round-robin order: 0 then 2, then 3 then 1.
    txn(4'b0101, 0, 2); chk("rr_a", 64'(last_w), 64'd0);
    txn(4'b0101, 1, 1); chk("rr_b", 64'(last_w), 64'd2);
    txn(4'b1010, 0, 3); chk("rr_c", 64'(last_w), 64'd3);
    txn(4'b1010, 0, 1); chk("rr_d", 64'(last_w), 64'd1);

    // Single request 100/7 with divider latency 5.
    dvd[1] = 32'd100; dvs[1] = 32'd7;
    txn(4'b0010, 0, 5);
    chk("single_q", 64'(resp_q), 64'd14);
    chk("single_r", 64'(resp_r), 64'd2);
    chk("single_e", 64'(resp_e), 64'd0);

    // Busy stall for three cycles.
    dvd[0] = 32'hFFFF_FF9C; dvs[0] = 32'd9;
    txn(4'b0001, 3, 2);

    // Divide by zero.
    dvd[3] = 32'd50; dvs[3] = '0;
    txn(4'b1000, 0, 3);
    chk("div0_err", 64'(resp_e), 64'd1);

    // Reset while waiting on the divider; late result must be dropped.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    pack();
    #1;
    chk("rst_grant", 64'(req_ready), 64'd1 << pick(4'b0100));
    @(posedge clk); #2;
    chk("rst_start", 64'(div_start), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    div_vin = 1'b1; div_q = 32'h1234; div_r = 32'h5678; div_e = 1'b1;
    #1;
    chk("late_noresp0", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    div_vin = 1'b0;
    #1;
    chk("late_noresp1", 64'(resp_valid), 64'd0);
    chk("late_noq", 64'(resp_q), 64'd0);
    ptr_m = 0;
    last_q = '0; last_r = '0; last_e = 1'b0;

    // Starvation: everyone valid, strict rotation from pointer 0.
    for (int i = 0; i < N; i++) served[i] = 0;
    for (int t = 0; t < 20; t++) begin
      txn(4'b1111, $urandom_range(0, 2), $urandom_range(1, 4));
      chk("rotation", 64'(last_w), 64'(t % N));
    end
    for (int i = 0; i < N; i++) chk("share", 64'(served[i]), 64'd5);

    // Random traffic.
    for (int t = 0; t < 40; t++)
      txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 6));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
